// File: rtl/ahb2apb_bridge_mslv_if.sv
// AHB-Lite slave side and APB master side signals of the AHB-to-APB bridge.
// The bridge uses the slave modport; the AHB master / APB slave environment uses master.
interface ahb2apb_bridge_mslv_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic [ADDR_W-1:0] paddr;
  logic [NUM_SLV-1:0] psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hwdata, hready, prdata, pready, pslverr,
    output hreadyout, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hwdata, hready, prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite slave to APB master bridge with one-hot PSEL decode and ERROR mapping.
// Optional ACCESS-phase timeout is enabled by defining BRIDGE_TIMEOUT_EN.
module ahb2apb_bridge_mslv #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic                   hclk,
  input logic                   hreset,
  ahb2apb_bridge_mslv_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StLatch, StSetup, StAccess, StDone, StErr1, StErr2
  } state_e;

  state_e state_q, state_d;

  logic              accept;
  logic              decoded;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [SEL_W-1:0]  idx_q;

  logic               hreadyout_q, hreadyout_d;
  logic               hresp_q, hresp_d;
  logic [DATA_W-1:0]  hrdata_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q;
  logic [DATA_W-1:0]  pwdata_q;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
`endif

  always_comb begin
    accept  = bus.hsel & bus.htrans[1] & bus.hready &
              (state_q inside {StIdle, StDone, StErr2});
    decoded = (32'(idx_q) < NUM_SLV);
    state_d = state_q;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
    timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif
    unique case (state_q)
      StIdle, StDone, StErr2: state_d = accept ? StLatch : StIdle;
      StLatch: begin
        state_d = decoded ? StSetup : StErr1;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (bus.pready) begin
          state_d = bus.pslverr ? StErr1 : StDone;
        end else begin
`ifdef BRIDGE_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (timeout) state_d = StErr1;
`endif
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    hreadyout_d = state_d inside {StIdle, StDone, StErr2};
    hresp_d     = state_d inside {StErr1, StErr2};
    penable_d   = (state_d == StAccess);
    psel_d      = '0;
    if (state_d inside {StSetup, StAccess}) psel_d = NUM_SLV'(1) << idx_q;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= StIdle;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
      if (accept) begin
        haddr_q  <= bus.haddr;
        hwrite_q <= bus.hwrite;
        idx_q    <= bus.haddr[ADDR_W-1 -: SEL_W];
      end
      if (state_q == StLatch) begin
        if (hwrite_q) pwdata_q <= bus.hwdata;
        // APB address/direction only change when an APB access actually starts.
        if (decoded) begin
          paddr_q  <= haddr_q;
          pwrite_q <= hwrite_q;
        end
      end
      if (state_q == StAccess && bus.pready && !bus.pslverr && !hwrite_q) begin
        hrdata_q <= bus.prdata;
      end
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Randomized bench for ahb2apb_bridge_mslv (3 APB slaves, so address field 3 is undecoded).
// Expected responses come from a transaction-level model of the bridge's AHB/APB behaviour.
module tb_ahb2apb_bridge_mslv;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned NSLV = 3;
  localparam int unsigned SELW = 2;
  localparam int unsigned TMO  = 16;

  logic hclk = 1'b0;
  logic hreset;

  ahb2apb_bridge_mslv_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NSLV)) bus_if ();

  ahb2apb_bridge_mslv #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NSLV), .SEL_W(SELW), .TIMEOUT_CYC(TMO)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus_if)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the bridge's visible holding registers.
  logic [DW-1:0] exp_hrdata, exp_pwdata;
  logic [AW-1:0] exp_paddr;
  logic          exp_pwrite;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Runs one AHB transfer; called at a negedge where HREADYOUT=1, returns at the negedge
  // where HREADYOUT is high again, so consecutive calls are back-to-back transfers.
  task automatic do_xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                         input int waits, input bit slverr, input logic [DW-1:0] rdata);
    int idx, exp_lat, exp_psel_cyc, cyc, psel_cyc, first_psel, acc, bad;
    bit dec, tmo, err, got_ready, err1_seen;
    logic [NSLV-1:0] exp_sel;
    idx = int'(addr[AW-1 -: SELW]);
    dec = (idx < NSLV);
    tmo = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    tmo = dec && (waits >= TMO);
`endif
    err          = !dec || tmo || slverr;
    exp_lat      = !dec ? 3 : tmo ? 4 + TMO : 4 + waits + (slverr ? 1 : 0);
    exp_psel_cyc = !dec ? 0 : tmo ? 1 + TMO : 2 + waits;
    exp_sel      = dec ? NSLV'(1 << idx) : '0;
    if (wr) exp_pwdata = wdata;
    if (dec) begin
      exp_paddr  = addr;
      exp_pwrite = wr;
    end

    bus_if.hsel   = 1'b1;
    bus_if.htrans = {1'b1, 1'($urandom)};
    bus_if.haddr  = addr;
    bus_if.hwrite = wr;
    @(posedge hclk);
    @(negedge hclk);
    bus_if.hwdata = wdata;
    bus_if.hsel   = 1'($urandom);
    bus_if.htrans = {1'b0, 1'($urandom)};
    bus_if.haddr  = 16'($urandom);
    bus_if.hwrite = 1'($urandom);

    cyc = 1; psel_cyc = 0; first_psel = 0; acc = 0; bad = 0;
    got_ready = 1'b0; err1_seen = 1'b0;
    while (cyc <= 64) begin
      if (bus_if.psel != '0) begin
        psel_cyc++;
        if (bus_if.psel !== exp_sel) bad++;
        if (first_psel == 0) begin
          first_psel = cyc;
          check_eq("setup_penable", 64'(bus_if.penable), 64'(0));
          check_eq("paddr", 64'(bus_if.paddr), 64'(exp_paddr));
          check_eq("pwrite", 64'(bus_if.pwrite), 64'(exp_pwrite));
          check_eq("pwdata", 64'(bus_if.pwdata), 64'(exp_pwdata));
        end
      end else if (bus_if.penable) begin
        bad++;
      end
      if (bus_if.psel != '0 && bus_if.penable) begin
        acc++;
        bus_if.pready  = (acc > waits);
        bus_if.pslverr = slverr;
        bus_if.prdata  = rdata;
      end else begin
        bus_if.pready  = 1'($urandom);
        bus_if.pslverr = 1'($urandom);
        bus_if.prdata  = $urandom;
      end
      if (bus_if.hreadyout) begin
        got_ready = 1'b1;
        break;
      end
      if (bus_if.hresp) err1_seen = 1'b1;
      @(negedge hclk);
      cyc++;
    end

    if (wr == 1'b0 && dec && !slverr && !tmo) exp_hrdata = rdata;
    check_eq("ready_seen", 64'(got_ready), 64'(1));
    check_eq("latency", 64'(cyc), 64'(exp_lat));
    check_eq("hresp", 64'(bus_if.hresp), 64'(err));
    check_eq("err1_cycle", 64'(err1_seen), 64'(err));
    check_eq("psel_cycles", 64'(psel_cyc), 64'(exp_psel_cyc));
    check_eq("psel_onehot_bad", 64'(bad), 64'(0));
    if (dec) check_eq("setup_cycle", 64'(first_psel), 64'(2));
    check_eq("hrdata", 64'(bus_if.hrdata), 64'(exp_hrdata));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.hsel   = 1'($urandom);
      bus_if.htrans = {1'b0, 1'($urandom)};
      bus_if.haddr  = 16'($urandom);
      @(negedge hclk);
      check_eq("idle_hreadyout", 64'(bus_if.hreadyout), 64'(1));
      check_eq("idle_psel", 64'(bus_if.psel), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset         = 1'b1;
    bus_if.hsel    = 1'b0;
    bus_if.haddr   = '0;
    bus_if.htrans  = 2'b00;
    bus_if.hwrite  = 1'b0;
    bus_if.hwdata  = '0;
    bus_if.hready  = 1'b1;
    bus_if.prdata  = '0;
    bus_if.pready  = 1'b0;
    bus_if.pslverr = 1'b0;
    exp_hrdata = '0; exp_pwdata = '0; exp_paddr = '0; exp_pwrite = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check_eq("rst_hreadyout", 64'(bus_if.hreadyout), 64'(1));
    check_eq("rst_hresp", 64'(bus_if.hresp), 64'(0));
    check_eq("rst_hrdata", 64'(bus_if.hrdata), 64'(0));
    check_eq("rst_paddr", 64'(bus_if.paddr), 64'(0));
    check_eq("rst_psel", 64'(bus_if.psel), 64'(0));
    check_eq("rst_penable", 64'(bus_if.penable), 64'(0));
    check_eq("rst_pwrite", 64'(bus_if.pwrite), 64'(0));
    check_eq("rst_pwdata", 64'(bus_if.pwdata), 64'(0));
    hreset = 1'b0;
    idle_cycles(2);

    // Directed: plain write, read with waits, slave error, undecoded, back-to-back writes.
    do_xfer(16'h4010, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    idle_cycles(1);
    do_xfer(16'h0004, 1'b0, 32'h0, 3, 1'b0, 32'h12345678);
    do_xfer(16'h8000, 1'b0, 32'h0, 0, 1'b1, 32'hBAD0BAD0);
    do_xfer(16'hC000, 1'b1, 32'hCAFEF00D, 0, 1'b0, 32'h0);
    do_xfer(16'h0100, 1'b1, 32'h11111111, 0, 1'b0, 32'h0);
    do_xfer(16'h4200, 1'b1, 32'h22222222, 1, 1'b0, 32'h0);
    idle_cycles(1);

    // Reset in the middle of an ACCESS phase drops the transfer.
    bus_if.hsel   = 1'b1;
    bus_if.htrans = 2'b10;
    bus_if.haddr  = 16'h0100;
    bus_if.hwrite = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    bus_if.htrans = 2'b00;
    bus_if.pready = 1'b0;
    repeat (2) @(negedge hclk);
    check_eq("pre_rst_penable", 64'(bus_if.penable), 64'(1));
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    check_eq("mid_rst_psel", 64'(bus_if.psel), 64'(0));
    check_eq("mid_rst_penable", 64'(bus_if.penable), 64'(0));
    check_eq("mid_rst_hreadyout", 64'(bus_if.hreadyout), 64'(1));
    check_eq("mid_rst_hrdata", 64'(bus_if.hrdata), 64'(0));
    exp_hrdata = '0; exp_pwdata = '0; exp_paddr = '0; exp_pwrite = 1'b0;
    idle_cycles(1);

`ifdef BRIDGE_TIMEOUT_EN
    do_xfer(16'h4000, 1'b0, 32'h0, 1000, 1'b0, 32'h55AA55AA);
    idle_cycles(1);
`endif

    for (int t = 0; t < 60; t++) begin
      do_xfer(16'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 4)),
              ($urandom_range(0, 5) == 0), $urandom);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
